// File: rtl/proc_reg_pkg.sv
// rtl/proc_reg_pkg.sv - shared op encoding and select-width helper for the multi-channel counter register
package proc_reg_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LD,
        OP_INC,
        OP_DEC
    } op_e;

    // A two-channel block still needs a one-bit select port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_reg_ch.sv
// rtl/counter_reg_ch.sv - one counter channel: priority decode, step arithmetic, sticky overflow
module counter_reg_ch
    import proc_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int WRAP  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] bin_i,
    input  logic             wr_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             ovf_clr_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum_w, diff_w;
    logic             step_ovf;
    op_e              op;

    // Top bit of the extended sum is the carry; of the extended difference, the borrow.
    assign sum_w  = {1'b0, cnt_q} + STEP_W;
    assign diff_w = {1'b0, cnt_q} - STEP_W;

    always_comb begin
        op = OP_HOLD;
        if (clr_i) begin
            op = OP_CLR;
        end else if (inc_i ^ dec_i) begin
            op = inc_i ? OP_INC : OP_DEC;
        end else if (wr_i) begin
            op = OP_LD;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        step_ovf = 1'b0;
        case (op)
            OP_CLR: cnt_d = '0;
            OP_LD:  cnt_d = bin_i;
            OP_INC: begin
                step_ovf = sum_w[WIDTH];
                cnt_d    = (sum_w[WIDTH] && (WRAP == 0)) ? '1 : sum_w[WIDTH-1:0];
            end
            OP_DEC: begin
                step_ovf = diff_w[WIDTH];
                cnt_d    = (diff_w[WIDTH] && (WRAP == 0)) ? '0 : diff_w[WIDTH-1:0];
            end
            default: cnt_d = cnt_q;
        endcase
        ovf_d = step_ovf | (ovf_q & ~ovf_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/multi_ch_counter_reg.sv
// rtl/multi_ch_counter_reg.sv - NUM_CH counter channels with registered zero-when-idle bus read-back
module multi_ch_counter_reg
    import proc_reg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = clog2_min1(NUM_CH),
    parameter int STEP   = 1,
    parameter int WRAP   = 1
) (
    input  logic                    clk,
    input  logic                    RST_N,
    input  logic [WIDTH-1:0]        BIN,
    input  logic [NUM_CH-1:0]       WR,
    input  logic [NUM_CH-1:0]       CLR,
    input  logic [NUM_CH-1:0]       INC,
    input  logic [NUM_CH-1:0]       DEC,
    input  logic [NUM_CH-1:0]       OVF_CLR,
    input  logic                    LDBUS,
    input  logic [SEL_W-1:0]        RSEL,
    output logic [WIDTH-1:0]        BOUT,
    output logic                    BOUT_VLD,
    output logic [NUM_CH-1:0]       OVF,
    output logic [NUM_CH*WIDTH-1:0] CNT_FLAT
);

    logic [WIDTH-1:0] cnt_w [NUM_CH];
    logic [WIDTH-1:0] rd_data;
    logic             rd_hit;
    logic [WIDTH-1:0] bout_q, bout_d;
    logic             bout_vld_q, bout_vld_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        counter_reg_ch #(
            .WIDTH (WIDTH),
            .STEP  (STEP),
            .WRAP  (WRAP)
        ) u_ch (
            .clk_i     (clk),
            .rst_ni    (RST_N),
            .bin_i     (BIN),
            .wr_i      (WR[i]),
            .clr_i     (CLR[i]),
            .inc_i     (INC[i]),
            .dec_i     (DEC[i]),
            .ovf_clr_i (OVF_CLR[i]),
            .cnt_o     (cnt_w[i]),
            .ovf_o     (OVF[i])
        );
        assign CNT_FLAT[i*WIDTH +: WIDTH] = cnt_w[i];
    end

    // Out-of-range selects match no channel, so the mux yields zero rather than X.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (RSEL == SEL_W'(i)) begin
                rd_data = cnt_w[i];
            end
        end
    end

    assign rd_hit     = LDBUS && (int'(RSEL) < NUM_CH);
    assign bout_d     = rd_hit ? rd_data : '0;
    assign bout_vld_d = rd_hit;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            bout_q     <= '0;
            bout_vld_q <= 1'b0;
        end else begin
            bout_q     <= bout_d;
            bout_vld_q <= bout_vld_d;
        end
    end

    assign BOUT     = bout_q;
    assign BOUT_VLD = bout_vld_q;

endmodule
